// File: rtl/sig_conflict_monitor.sv
// Safety watchdog on the highway/country lamp buses: checks aspect, sequence and yellow-dwell rules,
// latches the first violation with cause and road, and requests flash-red until acknowledged.
module sig_conflict_monitor #(
  parameter int MIN_YELLOW = 3,
  parameter int FLASH_DIV  = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clock,
  input  logic             clear,
  input  logic [1:0]       hwy,
  input  logic [1:0]       cntry,
  input  logic             fault_clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic             fault_road,
  output logic             flash,
  output logic [CNT_W-1:0] serve_cnt
);

  typedef enum logic [1:0] {ARM, RUN, FAULT} state_t;

  typedef enum logic [2:0] {
    C_NONE         = 3'd0,
    C_ILLEGAL      = 3'd1,
    C_CONFLICT     = 3'd2,
    C_SKIP_YELLOW  = 3'd3,
    C_BAD_SEQ      = 3'd4,
    C_SHORT_YELLOW = 3'd5
  } code_t;

  localparam logic [1:0] RED     = 2'd0;
  localparam logic [1:0] YELLOW  = 2'd1;
  localparam logic [1:0] GREEN   = 2'd2;
  localparam logic [1:0] ASP_BAD = 2'd3;

  localparam int              DW_W    = $clog2(MIN_YELLOW + 1);
  localparam logic [DW_W-1:0] MIN_Y   = DW_W'(MIN_YELLOW);
  localparam int              FL_W    = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [FL_W-1:0] FL_LAST = FL_W'(FLASH_DIV - 1);

  state_t          state, next_state;
  logic [1:0]      prev_hwy, prev_cntry;
  logic [DW_W-1:0] ydwell_h, ydwell_c;
  logic [FL_W-1:0] flash_cnt;
  code_t           fault_code_q;
  code_t           seq_h, seq_c, viol_code;
  logic            viol_road;
  logic            serve_hit;

  // Dwell counts consecutive yellow samples, including the one just taken.
  function automatic logic [DW_W-1:0] dwell_next(input logic [1:0] cur, input logic [1:0] prv,
                                                 input logic [DW_W-1:0] dw);
    if (cur != YELLOW) return '0;
    if (prv != YELLOW) return DW_W'(1);
    if (dw == '1)      return dw;
    return dw + DW_W'(1);
  endfunction

  function automatic code_t seq_check(input logic [1:0] cur, input logic [1:0] prv,
                                      input logic [DW_W-1:0] dw);
    code_t c;
    c = C_NONE;
    if (prv == GREEN && cur == RED)
      c = C_SKIP_YELLOW;
    else if ((prv == RED && cur == YELLOW) || (prv == YELLOW && cur == GREEN))
      c = C_BAD_SEQ;
    else if (prv == YELLOW && cur == RED && dw < MIN_Y)
      c = C_SHORT_YELLOW;
    return c;
  endfunction

  // NOTE: every variable driven here gets a default first, so no path can leave one unassigned (no latch).
  always_comb begin
    seq_h     = seq_check(hwy, prev_hwy, ydwell_h);
    seq_c     = seq_check(cntry, prev_cntry, ydwell_c);
    viol_code = C_NONE;
    viol_road = 1'b0;
    if (hwy == ASP_BAD) begin
      viol_code = C_ILLEGAL;
    end else if (cntry == ASP_BAD) begin
      viol_code = C_ILLEGAL;
      viol_road = 1'b1;
    end else if (hwy != RED && cntry != RED) begin
      viol_code = C_CONFLICT;
    end else if (seq_h != C_NONE && (seq_c == C_NONE || seq_h <= seq_c)) begin
      viol_code = seq_h;
    end else if (seq_c != C_NONE) begin
      viol_code = seq_c;
      viol_road = 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      ARM:     next_state = RUN;
      RUN:     if (viol_code != C_NONE) next_state = FAULT;
      FAULT:   if (fault_clr) next_state = ARM;
      default: next_state = ARM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= ARM;
    else       state <= next_state;
  end

  assign serve_hit = (state == RUN) && (prev_cntry == RED) && (cntry == GREEN);

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prev_hwy     <= RED;
      prev_cntry   <= RED;
      ydwell_h     <= '0;
      ydwell_c     <= '0;
      fault_code_q <= C_NONE;
      fault_road   <= 1'b0;
      flash        <= 1'b0;
      flash_cnt    <= '0;
      serve_cnt    <= '0;
    end else begin
      prev_hwy   <= hwy;
      prev_cntry <= cntry;
      ydwell_h   <= dwell_next(hwy, prev_hwy, ydwell_h);
      ydwell_c   <= dwell_next(cntry, prev_cntry, ydwell_c);

      if (serve_hit && serve_cnt != '1) serve_cnt <= serve_cnt + CNT_W'(1);

      unique case (state)
        RUN: begin
          if (viol_code != C_NONE) begin
            fault_code_q <= viol_code;
            fault_road   <= viol_road;
            flash        <= 1'b1;
            flash_cnt    <= '0;
          end
        end
        FAULT: begin
          // Acknowledge takes precedence over anything seen while faulted.
          if (fault_clr) begin
            fault_code_q <= C_NONE;
            fault_road   <= 1'b0;
            flash        <= 1'b0;
            flash_cnt    <= '0;
          end else if (flash_cnt == FL_LAST) begin
            flash     <= ~flash;
            flash_cnt <= '0;
          end else begin
            flash_cnt <= flash_cnt + FL_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign fault      = (state == FAULT);
  assign fault_code = fault_code_q;

endmodule

// File: tb/tb_sig_conflict_monitor.sv
// Self-checking bench for sig_conflict_monitor: a default instance and a CNT_W=2 instance share stimulus;
// per-cycle expectations go through a scoreboard queue and are compared one edge later.
module tb_sig_conflict_monitor;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] Y = 2'd1;
  localparam logic [1:0] G = 2'd2;
  localparam logic [1:0] X = 2'd3;

  logic       clock = 1'b0;
  logic       clear;
  logic [1:0] hwy, cntry;
  logic       fault_clr;

  logic       fault, fault_road, flash;
  logic [2:0] fault_code;
  logic [7:0] serve_cnt;

  logic       fault_s, fault_road_s, flash_s;
  logic [2:0] fault_code_s;
  logic [1:0] serve_cnt_s;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       f;
    logic [2:0] code;
    logic       road;
    logic       fl;
  } exp_t;

  exp_t sb[$];

  always #5 clock = ~clock;

  sig_conflict_monitor dut (
    .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry), .fault_clr(fault_clr),
    .fault(fault), .fault_code(fault_code), .fault_road(fault_road), .flash(flash),
    .serve_cnt(serve_cnt)
  );

  sig_conflict_monitor #(.CNT_W(2)) dut_sat (
    .clock(clock), .clear(clear), .hwy(hwy), .cntry(cntry), .fault_clr(fault_clr),
    .fault(fault_s), .fault_code(fault_code_s), .fault_road(fault_road_s), .flash(flash_s),
    .serve_cnt(serve_cnt_s)
  );

  function automatic exp_t e_ok();
    return '0;
  endfunction

  function automatic exp_t e_flt(input logic [2:0] c, input logic r, input logic fl);
    exp_t e;
    e.f    = 1'b1;
    e.code = c;
    e.road = r;
    e.fl   = fl;
    return e;
  endfunction

  // Starts and ends at a negedge; the expectation describes outputs just after the next posedge.
  task automatic step(input logic [1:0] h, input logic [1:0] c, input logic clr,
                      input exp_t e, input string tag);
    exp_t want;
    hwy       = h;
    cntry     = c;
    fault_clr = clr;
    sb.push_back(e);
    @(posedge clock);
    #1;
    want = sb.pop_front();
    vectors++;
    if ({fault, fault_code, fault_road, flash} !== want) begin
      miscompares++;
      $display("FAIL %s: got fault=%b code=%0d road=%b flash=%b, want fault=%b code=%0d road=%b flash=%b",
               tag, fault, fault_code, fault_road, flash, want.f, want.code, want.road, want.fl);
    end
    vectors++;
    if ({fault_s, fault_code_s, fault_road_s, flash_s} !== want) begin
      miscompares++;
      $display("FAIL %s(sat): got fault=%b code=%0d road=%b flash=%b, want fault=%b code=%0d road=%b flash=%b",
               tag, fault_s, fault_code_s, fault_road_s, flash_s, want.f, want.code, want.road, want.fl);
    end
    @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    clear     = 1'b1;
    hwy       = R;
    cntry     = R;
    fault_clr = 1'b0;
    repeat (5) @(negedge clock);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    clear     = 1'b1;
    hwy       = G;
    cntry     = G;
    fault_clr = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    vectors++;
    if ({fault, fault_code, fault_road, flash, serve_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL reset: got fault=%b code=%0d road=%b flash=%b serve=%0d, want all 0",
               fault, fault_code, fault_road, flash, serve_cnt);
    end
    vectors++;
    if ({fault_s, fault_code_s, fault_road_s, flash_s, serve_cnt_s} !== 8'd0) begin
      miscompares++;
      $display("FAIL reset(sat): got fault=%b code=%0d serve=%0d, want all 0", fault_s, fault_code_s, serve_cnt_s);
    end
    do_reset();
  endtask

  task automatic test_legal_cycle();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      repeat (10) step(G, R, 1'b0, e_ok(), "legal G/R");
      repeat (3)  step(Y, R, 1'b0, e_ok(), "legal Y/R");
      repeat (2)  step(R, R, 1'b0, e_ok(), "legal R/R");
      repeat (6)  step(R, G, 1'b0, e_ok(), "legal R/G");
      repeat (3)  step(R, Y, 1'b0, e_ok(), "legal R/Y");
      repeat (2)  step(R, R, 1'b0, e_ok(), "legal R/R");
      repeat (5)  step(G, R, 1'b0, e_ok(), "legal G/R");
    end
    vectors++;
    if (serve_cnt !== 8'd2) begin
      miscompares++;
      $display("FAIL legal serve_cnt: got %0d, want 2", serve_cnt);
    end
  endtask

  task automatic test_conflict();
    do_reset();
    step(G, R, 1'b0, e_ok(), "conflict arm");
    step(G, R, 1'b0, e_ok(), "conflict run");
    step(G, G, 1'b0, e_flt(3'd2, 1'b0, 1'b1), "conflict entry");
    for (int i = 1; i <= 8; i++)
      step(G, G, 1'b0, e_flt(3'd2, 1'b0, ((i / 4) % 2) == 0), "conflict flash");
    step(G, G, 1'b1, e_ok(), "conflict ack");
  endtask

  task automatic test_short_yellow();
    do_reset();
    step(R, R, 1'b0, e_ok(), "short arm");
    step(R, R, 1'b0, e_ok(), "short R/R");
    repeat (2) step(R, G, 1'b0, e_ok(), "short R/G");
    repeat (2) step(R, Y, 1'b0, e_ok(), "short R/Y");
    step(R, R, 1'b0, e_flt(3'd5, 1'b1, 1'b1), "short yellow 2");
    do_reset();
    step(R, R, 1'b0, e_ok(), "min arm");
    step(R, R, 1'b0, e_ok(), "min R/R");
    step(R, G, 1'b0, e_ok(), "min R/G");
    repeat (3) step(R, Y, 1'b0, e_ok(), "min R/Y");
    repeat (2) step(R, R, 1'b0, e_ok(), "min yellow 3");
  endtask

  task automatic test_priority();
    do_reset();
    step(R, R, 1'b0, e_ok(), "prio arm");
    step(R, R, 1'b0, e_ok(), "prio run");
    step(X, G, 1'b0, e_flt(3'd1, 1'b0, 1'b1), "illegal beats conflict");
    do_reset();
    step(R, R, 1'b0, e_ok(), "prio arm");
    step(R, R, 1'b0, e_ok(), "prio run");
    step(R, X, 1'b0, e_flt(3'd1, 1'b1, 1'b1), "illegal cntry");
    do_reset();
    step(R, R, 1'b0, e_ok(), "prio arm");
    step(R, R, 1'b0, e_ok(), "prio run");
    step(X, X, 1'b0, e_flt(3'd1, 1'b0, 1'b1), "illegal both hwy wins");
    do_reset();
    step(G, R, 1'b0, e_ok(), "prio arm");
    step(G, R, 1'b0, e_ok(), "prio run");
    step(R, R, 1'b0, e_flt(3'd3, 1'b0, 1'b1), "skip yellow hwy");
    do_reset();
    step(R, R, 1'b0, e_ok(), "prio arm");
    step(R, R, 1'b0, e_ok(), "prio run");
    step(Y, R, 1'b0, e_flt(3'd4, 1'b0, 1'b1), "bad seq R->Y");
  endtask

  task automatic test_clear_recovery();
    do_reset();
    step(G, R, 1'b0, e_ok(), "recov arm");
    step(G, R, 1'b0, e_ok(), "recov run");
    step(G, G, 1'b0, e_flt(3'd2, 1'b0, 1'b1), "recov fault");
    step(X, G, 1'b1, e_ok(), "ack beats violation");
    step(R, R, 1'b0, e_ok(), "arm skips sequence");
    step(R, R, 1'b0, e_ok(), "run after arm");
    step(R, R, 1'b1, e_ok(), "ack ignored in run");
    step(X, R, 1'b0, e_flt(3'd1, 1'b0, 1'b1), "illegal after rearm");
    #2;
    clear = 1'b1;
    #1;
    vectors++;
    if ({fault, fault_code, fault_road, flash, serve_cnt} !== 14'd0) begin
      miscompares++;
      $display("FAIL async clear: got fault=%b code=%0d road=%b flash=%b serve=%0d, want all 0",
               fault, fault_code, fault_road, flash, serve_cnt);
    end
    @(negedge clock);
    clear = 1'b0;
    hwy   = R;
    cntry = R;
  endtask

  task automatic test_saturation();
    do_reset();
    step(R, R, 1'b0, e_ok(), "sat arm");
    for (int n = 1; n <= 5; n++) begin
      step(R, R, 1'b0, e_ok(), "sat R/R");
      step(R, G, 1'b0, e_ok(), "sat R/G");
      vectors++;
      if (serve_cnt !== 8'(n)) begin
        miscompares++;
        $display("FAIL serve_cnt service %0d: got %0d, want %0d", n, serve_cnt, n);
      end
      vectors++;
      if (serve_cnt_s !== 2'((n > 3) ? 3 : n)) begin
        miscompares++;
        $display("FAIL serve_cnt sat service %0d: got %0d, want %0d", n, serve_cnt_s, (n > 3) ? 3 : n);
      end
      repeat (3) step(R, Y, 1'b0, e_ok(), "sat R/Y");
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear     = 1'b1;
    hwy       = R;
    cntry     = R;
    fault_clr = 1'b0;
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_short_yellow();
    test_priority();
    test_clear_recovery();
    test_saturation();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
